// File: rtl/alu_cmd_queue.sv
// Command FIFO in front of the ALU: filters illegal opcodes,
// counts drops, and presents the head entry on the ALU ports.
module alu_cmd_queue #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  input  logic [DATA_WIDTH-1:0]     IN_OP1,
  input  logic [DATA_WIDTH-1:0]     IN_OP2,
  input  logic [OPRN_WIDTH-1:0]     IN_OPRN,
  output logic                      ISSUE_VALID,
  input  logic                      ISSUE_READY,
  output logic [DATA_WIDTH-1:0]     ALU_OP1,
  output logic [DATA_WIDTH-1:0]     ALU_OP2,
  output logic [OPRN_WIDTH-1:0]     ALU_OPRN,
  output logic [$clog2(DEPTH):0]    COUNT,
  output logic [7:0]                ERR_CNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] op1_mem [DEPTH];
  logic [DATA_WIDTH-1:0] op2_mem [DEPTH];
  logic [OPRN_WIDTH-1:0] oprn_mem [DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [7:0]    err_cnt;
  logic          live;

  logic legal;
  logic take;
  logic push;
  logic drop;
  logic pop;

  // live holds IN_READY low until the first edge after reset release
  assign IN_READY    = live && (count != CW'(DEPTH));
  assign ISSUE_VALID = (count != '0);

  assign legal = (IN_OPRN != '0) &&
                 (IN_OPRN <= OPRN_WIDTH'(9));
  assign take  = IN_VALID & IN_READY;
  assign push  = take & legal;
  assign drop  = take & ~legal;
  assign pop   = ISSUE_VALID & ISSUE_READY;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      live <= 1'b0;
    end else begin
      live <= 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        op1_mem[i]  <= '0;
        op2_mem[i]  <= '0;
        oprn_mem[i] <= '0;
      end
    end else if (push) begin
      op1_mem[wr_ptr]  <= IN_OP1;
      op2_mem[wr_ptr]  <= IN_OP2;
      oprn_mem[wr_ptr] <= IN_OPRN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt <= '0;
    end else if (drop && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  // idle ALU sees OPRN 0, never stale storage
  always_comb begin
    ALU_OP1  = '0;
    ALU_OP2  = '0;
    ALU_OPRN = '0;
    if (ISSUE_VALID) begin
      ALU_OP1  = op1_mem[rd_ptr];
      ALU_OP2  = op2_mem[rd_ptr];
      ALU_OPRN = oprn_mem[rd_ptr];
    end
  end

  assign COUNT   = count;
  assign ERR_CNT = err_cnt;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Scoreboard bench for alu_cmd_queue: directed phases
// followed by randomized traffic against a queue model.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int OW    = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [DW-1:0] IN_OP1 = '0;
  logic [DW-1:0] IN_OP2 = '0;
  logic [OW-1:0] IN_OPRN = '0;
  logic          ISSUE_VALID;
  logic          ISSUE_READY = 1'b0;
  logic [DW-1:0] ALU_OP1;
  logic [DW-1:0] ALU_OP2;
  logic [OW-1:0] ALU_OPRN;
  logic [2:0]    COUNT;
  logic [7:0]    ERR_CNT;

  alu_cmd_queue #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .OPRN_WIDTH(OW)
  ) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_OP1(IN_OP1), .IN_OP2(IN_OP2), .IN_OPRN(IN_OPRN),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_READY(ISSUE_READY),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .COUNT(COUNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
  } ent_t;

  ent_t sb[$];
  int   err_exp  = 0;
  int   checks   = 0;
  int   failures = 0;
  int   issued   = 0;
  bit   m_live   = 1'b0;

  task automatic chk(string name, longint got, longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Model: ready comes up on the first clock edge after reset release
  always @(posedge CLK or posedge RST) begin
    if (RST) m_live <= 1'b0;
    else     m_live <= 1'b1;
  end

  always @(posedge RST) begin
    sb.delete();
    err_exp = 0;
  end

  // Inputs are stable at negedge; handshakes seen here happen next posedge
  always @(negedge CLK) begin
    if (!RST) begin
      int  n;
      bit  rdy;
      ent_t e;
      n   = sb.size();
      rdy = m_live && (n != DEPTH);
      chk("in_ready", IN_READY, rdy);
      chk("issue_valid", ISSUE_VALID, n != 0);
      chk("count", COUNT, n);
      chk("err_cnt", ERR_CNT, err_exp);
      if (n == 0) begin
        chk("idle_oprn", ALU_OPRN, 0);
        chk("idle_ops", ALU_OP1 | ALU_OP2, 0);
      end else begin
        e = sb[0];
        chk("head_op1", ALU_OP1, e.a);
        chk("head_op2", ALU_OP2, e.b);
        chk("head_oprn", ALU_OPRN, e.op);
        if (ISSUE_READY) begin
          void'(sb.pop_front());
          issued++;
        end
      end
      if (IN_VALID && rdy) begin
        if (IN_OPRN >= 1 && IN_OPRN <= 9) begin
          e.a  = IN_OP1;
          e.b  = IN_OP2;
          e.op = IN_OPRN;
          sb.push_back(e);
        end else if (err_exp < 255) begin
          err_exp++;
        end
      end
    end
  end

  task automatic drive(bit v, logic [OW-1:0] op, bit rdy);
    @(posedge CLK);
    #1;
    IN_VALID    = v;
    IN_OP1      = $urandom;
    IN_OP2      = $urandom;
    IN_OPRN     = op;
    ISSUE_READY = rdy;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    IN_VALID    = 1'b0;
    ISSUE_READY = 1'b0;
    RST         = 1'b1;
    #1;
    chk("rst_count", COUNT, 0);
    chk("rst_issue_valid", ISSUE_VALID, 0);
    chk("rst_alu_oprn", ALU_OPRN, 0);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_err_cnt", ERR_CNT, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    logic [OW-1:0] op;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    // Reset mid-stream
    for (int i = 1; i <= 3; i++) drive(1'b1, OW'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    do_reset();

    // Fill, then a fifth push while full
    for (int i = 1; i <= 5; i++) drive(1'b1, OW'(i), 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge CLK);
    chk("fill_count", COUNT, 4);
    chk("fill_in_ready", IN_READY, 0);
    chk("fill_head", ALU_OPRN, 1);

    // Drain in order
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("drain_empty", ISSUE_VALID, 0);

    // Illegal filter
    op = 6'h00; drive(1'b1, op, 1'b0);
    op = 6'h0A; drive(1'b1, op, 1'b0);
    op = 6'h3F; drive(1'b1, op, 1'b0);
    op = 6'h09; drive(1'b1, op, 1'b0);
    drive(1'b0, '0, 1'b0);
    @(negedge CLK);
    chk("illegal_err", ERR_CNT, 3);
    chk("legal9_count", COUNT, 1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b0);

    // Streaming through the wrap point
    @(negedge CLK);
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, OW'($urandom_range(1, 9)), 1'b1);
    end
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("stream_issues", issued, 10);

    // Illegal-count saturation
    for (int i = 0; i < 260; i++) begin
      drive(1'b1, ($urandom % 2) ? 6'h00 : 6'h3F, 1'b0);
    end
    drive(1'b0, '0, 1'b0);
    @(negedge CLK);
    chk("err_sat", ERR_CNT, 8'hFF);

    do_reset();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) op = OW'($urandom_range(1, 9));
      else op = OW'($urandom_range(0, 63));
      drive(1'($urandom), op, 1'($urandom));
      if (i == 300) do_reset();
    end
    drive(1'b0, '0, 1'b1);
    repeat (DEPTH + 1) drive(1'b0, '0, 1'b1);
    @(negedge CLK);
    chk("final_empty", COUNT, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
